// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg
// Shared definitions for the sweep sequencer: FSM state encoding and the
// default datapath widths used by the top level and the bench.
package count_sequencer_pkg;

    // Default value / end-value width (12-bit sweep datapath).
    localparam int DEF_WIDTH     = 12;
    // Default width of the inter-value delay count.
    localparam int DEF_DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/count_sequencer_rate_timer.sv
// count_sequencer_rate_timer
// Loadable down-counter that times the gap between an accepted value and
// the next offer. The count freezes while hold is high.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : force the count to zero (wins over load)
//   load       : load load_val into the count
//   load_val   : delay length in cycles
//   en         : counting enabled (sequencer is waiting)
//   hold       : freeze the count (pause)
//   tc         : terminal-count pulse, high in the cycle the count steps 1 -> 0
module count_sequencer_rate_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] load_val,
    input  logic                 en,
    input  logic                 hold,
    output logic                 tc
);

    logic [DIV_WIDTH-1:0] count;
    logic                 step;

    assign step = en && !hold && (count != '0);
    assign tc   = step && (count == DIV_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (step) begin
            count <= count - DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer
// Walks value from 0 to a latched end value, offering each value downstream
// over valid/ready, with a programmable idle gap between values. Supports
// pause (freezes the gap), abort (back to IDLE) and restart from DONE.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   start        : begin a sweep (honoured in IDLE or DONE only)
//   abort        : end the sweep, return to IDLE (highest priority)
//   pause        : level; freezes the inter-value delay
//   end_val      : last sweep value, latched on accepted start
//   rate_div     : idle cycles between values, latched on accepted start
//   value        : current sweep value
//   value_valid  : value offered downstream
//   value_ready  : downstream accepts
//   busy         : sweep in progress (EMIT or WAIT)
//   done         : sweep completed (DONE)
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic [WIDTH-1:0]     end_val,
    input  logic [DIV_WIDTH-1:0] rate_div,
    output logic [WIDTH-1:0]     value,
    output logic                 value_valid,
    input  logic                 value_ready,
    output logic                 busy,
    output logic                 done
);

    state_t               state, state_n;
    logic [WIDTH-1:0]     value_n;
    logic [WIDTH-1:0]     end_lat, end_n;
    logic [DIV_WIDTH-1:0] rate_lat, rate_n;
    logic                 tmr_load, tmr_clear, tmr_tc;

    count_sequencer_rate_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_rate_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (rate_lat),
        .en       (state == S_WAIT),
        .hold     (pause),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            value    <= '0;
            end_lat  <= '0;
            rate_lat <= '0;
        end else begin
            state    <= state_n;
            value    <= value_n;
            end_lat  <= end_n;
            rate_lat <= rate_n;
        end
    end

    always_comb begin
        state_n   = state;
        value_n   = value;
        end_n     = end_lat;
        rate_n    = rate_lat;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;

        if (abort) begin
            // A transfer in this cycle still completes downstream; we just
            // do not advance past it.
            state_n   = S_IDLE;
            value_n   = '0;
            tmr_clear = 1'b1;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        end_n   = end_val;
                        rate_n  = rate_div;
                        value_n = '0;
                        state_n = S_EMIT;
                    end
                end
                S_EMIT: begin
                    // value_valid is high throughout EMIT, so ready alone
                    // marks a transfer.
                    if (value_ready) begin
                        if (value == end_lat) begin
                            // Final value holds; no increment, so no wrap
                            // at the top of the range.
                            state_n = S_DONE;
                        end else begin
                            value_n = value + WIDTH'(1);
                            if (rate_lat != '0) begin
                                tmr_load = 1'b1;
                                state_n  = S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (tmr_tc) begin
                        state_n = S_EMIT;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register only; no input reaches them
    // combinationally.
    assign value_valid = (state == S_EMIT);
    assign busy        = (state == S_EMIT) || (state == S_WAIT);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;
    localparam int W = 12;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         pause = 1'b0;
    logic         value_ready = 1'b0;
    logic [W-1:0] end_val = '0;
    logic [D-1:0] rate_div = '0;
    logic [W-1:0] value;
    logic         value_valid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(W), .DIV_WIDTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .end_val     (end_val),
        .rate_div    (rate_div),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
        .done        (done)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: "active" sweep, next value, remaining idle gap.
    bit m_active, m_done;
    int m_val, m_end, m_rate, m_gap;

    int cyc = 0;
    int xq_val[$];
    int xq_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_active = 0; m_done = 0; m_val = 0; m_end = 0; m_rate = 0; m_gap = 0;
    endtask

    task automatic m_edge();
        if (!rst) begin
            m_reset();
        end else if (abort) begin
            m_active = 0; m_done = 0; m_val = 0; m_gap = 0;
        end else if (!m_active) begin
            if (start) begin
                m_end = int'(end_val); m_rate = int'(rate_div);
                m_val = 0; m_active = 1; m_done = 0; m_gap = 0;
            end
        end else if (m_gap > 0) begin
            if (!pause) m_gap--;
        end else if (value_ready) begin
            if (m_val == m_end) begin
                m_active = 0; m_done = 1;
            end else begin
                m_val++; m_gap = m_rate;
            end
        end
    endtask

    task automatic chk_outputs();
        chk("value", value, m_val);
        chk("valid", value_valid, m_active && m_gap == 0);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
    endtask

    // Called at a negedge with inputs already set for the coming edge.
    task automatic cycle();
        if (value_valid && value_ready) begin
            xq_val.push_back(int'(value));
            xq_cyc.push_back(cyc);
        end
        @(posedge clk);
        m_edge();
        cyc++;
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) cycle();
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic begin_sweep(input int e, input int r);
        xq_val.delete(); xq_cyc.delete();
        end_val = W'(e); rate_div = D'(r); start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        m_reset();
        repeat (3) @(negedge clk);
        chk_outputs();
        rst = 1'b1;
        cycle();

        // Basic sweep 0..3, back to back
        value_ready = 1'b1;
        begin_sweep(3, 0);
        run_until_idle(20);
        chk("s1_count", xq_val.size(), 4);
        for (int i = 0; i < xq_val.size(); i++) begin
            chk("s1_val", xq_val[i], i);
            if (i > 0) chk("s1_gap", xq_cyc[i] - xq_cyc[i-1], 1);
        end
        chk("s1_done", done, 1'b1);
        chk("s1_last", value, 3);

        // Rate 4 with a 3-cycle pause in the first WAIT
        begin_sweep(2, 4);
        for (int i = 0; i < 20 && xq_val.size() < 1; i++) cycle();
        pause = 1'b1;
        repeat (3) cycle();
        pause = 1'b0;
        run_until_idle(40);
        chk("s2_count", xq_val.size(), 3);
        if (xq_val.size() == 3) begin
            chk("s2_gap_paused", xq_cyc[1] - xq_cyc[0], 8);
            chk("s2_gap", xq_cyc[2] - xq_cyc[1], 5);
        end

        // Back-pressure
        value_ready = 1'b0;
        begin_sweep(1, 0);
        repeat (6) begin
            cycle();
            chk("s3_hold_valid", value_valid, 1'b1);
            chk("s3_hold_value", value, 0);
        end
        value_ready = 1'b1;
        run_until_idle(10);
        chk("s3_count", xq_val.size(), 2);
        if (xq_val.size() == 2) begin
            chk("s3_v0", xq_val[0], 0);
            chk("s3_v1", xq_val[1], 1);
        end

        // Abort beats start and a same-cycle transfer
        begin_sweep(10, 0);
        for (int i = 0; i < 20 && !(value_valid && value == W'(5)); i++) cycle();
        chk("s4_reach", value, 5);
        abort = 1'b1; start = 1'b1;
        cycle();
        abort = 1'b0; start = 1'b0;
        chk("s4_value", value, 0);
        chk("s4_valid", value_valid, 1'b0);
        chk("s4_busy", busy, 1'b0);
        chk("s4_done", done, 1'b0);
        repeat (3) cycle();
        chk("s4_stay_idle", busy, 1'b0);

        // end_val = 0
        begin_sweep(0, 3);
        run_until_idle(10);
        chk("s5_count", xq_val.size(), 1);
        if (xq_val.size() == 1) chk("s5_v0", xq_val[0], 0);
        chk("s5_done", done, 1'b1);

        // Full range, no wrap
        begin_sweep(4095, 0);
        run_until_idle(5000);
        chk("s6_count", xq_val.size(), 4096);
        for (int i = 0; i < xq_val.size(); i++) chk("s6_val", xq_val[i], i);
        chk("s6_last", value, 4095);
        chk("s6_done", done, 1'b1);

        // Restart from DONE
        begin_sweep(2, 1);
        run_until_idle(20);
        chk("s7_count", xq_val.size(), 3);
        for (int i = 0; i < xq_val.size(); i++) chk("s7_val", xq_val[i], i);

        // Asynchronous reset mid-WAIT, between edges
        begin_sweep(5, 10);
        repeat (4) cycle();
        chk("s8_pre_busy", busy, 1'b1);
        chk("s8_pre_value", value, 1);
        #2 rst = 1'b0;
        #1;
        chk("s8_value", value, 0);
        chk("s8_valid", value_valid, 1'b0);
        chk("s8_busy", busy, 1'b0);
        chk("s8_done", done, 1'b0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            start       = ($urandom % 4) == 0;
            abort       = ($urandom % 40) == 0;
            pause       = ($urandom % 3) == 0;
            value_ready = ($urandom % 4) != 0;
            end_val     = W'($urandom % 8);
            rate_div    = D'($urandom % 4);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Sequencer for the lab's 12-bit sweep datapath: on command it walks a value from 0 to a programmed end value and presents each value to a downstream consumer (the binary-to-BCD/display path) over a valid/ready handshake. Between values it waits a programmable number of clock cycles. It supports pause, abort and restart, and flags completion. It replaces free-running counting with a controlled, rate-limited, back-pressured sweep.

## Interface
- `WIDTH`, default 12: value / end-value width.
- `DIV_WIDTH`, default 16: width of the inter-value delay count.
- `clk` input, 1 bit: single clock. All state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a sweep. Honoured only in IDLE or DONE.
- `abort` input, 1 bit: end the sweep immediately and return to IDLE.
- `pause` input, 1 bit: level. While high, the inter-value delay is frozen.
- `end_val` input, WIDTH: last value of the sweep. Latched on accepted `start`.
- `rate_div` input, DIV_WIDTH: idle cycles between an accepted value and the next valid. Latched on accepted `start`.
- `value` output, WIDTH: current sweep value.
- `value_valid` output, 1 bit: `value` is offered downstream.
- `value_ready` input, 1 bit: downstream accepts. A transfer happens on a cycle where `value_valid` and `value_ready` are both high.
- `busy` output, 1 bit: high in EMIT or WAIT.
- `done` output, 1 bit: high in DONE.

## Operation
- States are IDLE, EMIT, WAIT and DONE.
- **Reset values:** state=IDLE, `value`=0, `value_valid`=0, `busy`=0, `done`=0, delay counter=0, latched end/rate=0.
- **IDLE:**
  - On `start` (and no `abort`): latch `end_val` and `rate_div`, set `value`=0, go to EMIT.
- **EMIT:**
  - `value_valid`=1.
  - While `value_ready`=0, hold `value` and valid. Once asserted, valid is never withdrawn except by `abort` or reset.
  - On transfer with `value`==latched end: go to DONE. `value` holds the last value; valid drops.
  - On transfer otherwise: `value`←`value`+1.
    - If latched rate=0, stay in EMIT. This gives back-to-back transfers, one value per cycle.
    - If latched rate>0, load the delay counter with latched rate and go to WAIT.
- **WAIT:**
  - `value_valid`=0.
  - When `pause`=0, the counter decrements by 1 each cycle. When `pause`=1, it holds.
  - When the counter reaches 1 and decrements, go to EMIT. This gives exactly `rate_div` unpaused cycles with valid low.
- **DONE:**
  - `done`=1 and `value` holds.
  - `start` restarts exactly as from IDLE.
- **`abort`:**
  - In any state, abort moves to IDLE on the next edge with `value`=0, valid=0, `done`=0.
  - `abort` has priority over `start`, over a transfer in the same cycle, and over `pause`.
  - A transfer coinciding with `abort` still completes downstream. The sequencer simply does not advance.
- **`pause` in EMIT** has no effect; the offer stands.
- **`start` while busy** is ignored. It does not re-latch `end_val` or `rate_div`.
- **Changing `end_val` or `rate_div` mid-sweep** has no effect; only the latched copies are used.
- **Arithmetic:**
  - `value` never wraps, because the sweep ends at end ≤ 2^WIDTH−1. With `end_val`=4095, the final value is 4095 and `value` is not incremented past it.
  - `end_val`=0 gives a single transfer of 0.
- **Reset mid-sweep:** outputs go to their reset values asynchronously. After release, the sequencer sits in IDLE until `start`.

## Timing
- `start` sampled high at edge N → `value_valid`=1 with `value`=0 after edge N; it is visible in cycle N+1.
- With rate=R>0 and downstream always ready:
  - One transfer every R+1 cycles.
  - Value k is transferred in cycle N+1+k·(R+1).
- With rate=0 and ready held high: one transfer per cycle. The sweep 0..E takes E+1 cycles of valid.
- Final transfer at edge M → `done`=1 and `busy`=0 from cycle M+1.
- All outputs are registered; there is no combinational path from any input to any output.
- `value_ready` affects state only at the edge.

## Structure
- A shared package holds:
  - the state enum (IDLE, EMIT, WAIT, DONE);
  - default `WIDTH` = 12 and `DIV_WIDTH` = 16 constants.
- One natural sub-module is `rate_timer`: a loadable down-counter with a hold (pause) input and a terminal-count pulse, used by WAIT.
- The FSM, value register and latches stay in the top level.

## Test plan
- **Reset and basic sweep:**
  - Hold `rst`=0, check all outputs are 0.
  - Release, `start` with `end_val`=3, `rate_div`=0, ready=1.
  - Expect values 0,1,2,3 on 4 consecutive cycles, then `done`=1, `value`=3, valid=0.
- **Rate and pause:**
  - `end_val`=2, `rate_div`=4, ready=1.
  - Expect transfers 5 cycles apart.
  - Assert `pause` for 3 cycles inside a WAIT; expect that gap to stretch to 8 cycles.
- **Back-pressure:**
  - `end_val`=1, ready=0 for 6 cycles after valid rises.
  - Expect valid=1 and `value`=0 held throughout, then transfers of 0 and 1 once ready=1.
- **Abort priority:**
  - Mid-sweep at `value`=5, assert `abort` and `start` in the same cycle as a transfer.
  - Expect IDLE next cycle with `value`=0, valid=0, `busy`=0, and no new sweep.
- **Boundaries:**
  - `end_val`=0: expect a single transfer of 0, then `done`.
  - `end_val`=4095, `rate_div`=0: expect 4096 transfers ending at 4095 with no wrap to 0.
- **Restart and asynchronous reset:**
  - From DONE, `start` with new `end_val`=2; expect a fresh sweep 0..2.
  - Pulse `rst` low mid-WAIT, between clock edges; expect outputs cleared immediately, without waiting for a clock edge.
